// File: rtl/cell_array_pkg.sv
// cell_array_pkg: shared state encoding, array defaults and slot derivation for the cell array
package cell_array_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  localparam int DEF_DIMX = 64;
  localparam int DEF_DIMY = 64;
  localparam int DEF_PORT_WIDTH = 32;
  function automatic int slots_f(input int dimx, input int port_width);
    return dimx * 4 / port_width;
  endfunction
endpackage

// File: rtl/row_config_loader.sv
// row_config_loader: streams config words onto the shared cell RAM bus, pulsing one row/slot write enable per word
// ports: clk, rst_n (async, active-low); start begins a full-array load from IDLE;
//        in_data/in_valid/in_ready word handshake; ram shared bus; write_en flattened row*SLOTS+slot enables;
//        busy high in LOAD and DONE; done one-cycle pulse aligned with the final write
module row_config_loader
  import cell_array_pkg::*;
#(
  parameter int DIMX = DEF_DIMX,
  parameter int DIMY = DEF_DIMY,
  parameter int PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int SLOTS = slots_f(DIMX, PORT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [PORT_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DIMX*4-1:0]       ram,
  output logic [DIMY*SLOTS-1:0]   write_en,
  output logic                    busy,
  output logic                    done
);
  localparam int ROW_W = DIMY > 1 ? $clog2(DIMY) : 1;
  localparam int SLOT_W = SLOTS > 1 ? $clog2(SLOTS) : 1;
  localparam int NW = DIMY * SLOTS;
  state_e state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DIMX*4-1:0] ram_q, ram_d;
  logic [NW-1:0] we_q, we_d;
  logic accept, last_slot, last_row;
  assign accept = state_q == LOAD && in_valid;
  assign last_slot = slot_q == SLOT_W'(SLOTS - 1);
  assign last_row = row_q == ROW_W'(DIMY - 1);
  always_comb begin
    state_d = state_q == DONE ? IDLE : state_q;
    row_d = row_q;
    slot_d = slot_q;
    ram_d = ram_q;
    we_d = accept ? NW'(1) << (int'(row_q) * SLOTS + int'(slot_q)) : '0;
    if (state_q == IDLE && start) begin
      state_d = LOAD;
      row_d = '0;
      slot_d = '0;
    end
    if (accept) begin
      for (int s = 0; s < SLOTS; s++)
        if (slot_q == SLOT_W'(s)) ram_d[s*PORT_WIDTH +: PORT_WIDTH] = in_data;
      slot_d = last_slot ? '0 : slot_q + SLOT_W'(1);
      row_d = last_slot ? row_q + ROW_W'(1) : row_q;
      state_d = last_slot && last_row ? DONE : LOAD;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= '0;
      slot_q <= '0;
      ram_q <= '0;
      we_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      slot_q <= slot_d;
      ram_q <= ram_d;
      we_q <= we_d;
    end
  end
  assign ram = ram_q;
  assign write_en = we_q;
  assign in_ready = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
